iob2axil_bridge: RTL and testbench

IOB2AXIL_BRIDGE -- requirements
Module: iob2axil_bridge

---
 rtl/iob2axil_bridge_pkg.sv | 28 ++
 rtl/iob2axil_bridge_if.sv | 83 ++++++++
 rtl/iob2axil_bridge.sv | 199 +++++++++++++++++++
 tb/tb_iob2axil_bridge.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iob2axil_bridge_pkg.sv
// Shared types and constants for the IOb to AXI-Lite bridge.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: FSM state encoding, AXI response codes, default PROT value and a
// helper that classifies an AXI response as an error.
package iob2axil_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        WR_ADDR_DATA = 3'd1,
        WR_RESP      = 3'd2,
        RD_ADDR      = 3'd3,
        RD_RESP      = 3'd4
    } state_t;

    typedef logic [1:0] axi_resp_t;

    localparam axi_resp_t  RESP_OKAY         = 2'b00;
    localparam axi_resp_t  RESP_SLVERR       = 2'b10;
    localparam logic [2:0] AXIL_PROT_DEFAULT = 3'd2;

    // Anything other than OKAY (SLVERR, DECERR, EXOKAY) is an error on AXI-Lite.
    function automatic logic resp_is_err(input axi_resp_t resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/iob2axil_bridge_if.sv
// Bus bundle between an IOb requester and an AXI-Lite subordinate.
// Latency: n/a (wires only).
// Backpressure: n/a; flow control is the IOb ready and the AXI valid/ready pairs.
//
// Modports: master = the bridge (IOb target side, AXI-Lite manager side);
//           slave  = the environment (IOb requester plus AXI-Lite subordinate).
interface iob2axil_bridge_if
    import iob2axil_bridge_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int AXIL_ADDR_W = 32,
    parameter int AXIL_DATA_W = 32
);
    // IOb request / response
    logic                     iob_valid;
    logic [ADDR_W-1:0]        iob_addr;
    logic [DATA_W-1:0]        iob_wdata;
    logic [DATA_W/8-1:0]      iob_wstrb;
    logic                     iob_ready;
    logic                     iob_rvalid;
    logic [DATA_W-1:0]        iob_rdata;

    // AXI-Lite write address
    logic                     axil_awvalid;
    logic                     axil_awready;
    logic [AXIL_ADDR_W-1:0]   axil_awaddr;
    logic [2:0]               axil_awprot;

    // AXI-Lite write data
    logic                     axil_wvalid;
    logic                     axil_wready;
    logic [AXIL_DATA_W-1:0]   axil_wdata;
    logic [AXIL_DATA_W/8-1:0] axil_wstrb;

    // AXI-Lite write response
    logic                     axil_bvalid;
    logic                     axil_bready;
    axi_resp_t                axil_bresp;

    // AXI-Lite read address
    logic                     axil_arvalid;
    logic                     axil_arready;
    logic [AXIL_ADDR_W-1:0]   axil_araddr;
    logic [2:0]               axil_arprot;

    // AXI-Lite read data
    logic                     axil_rvalid;
    logic                     axil_rready;
    logic [AXIL_DATA_W-1:0]   axil_rdata;
    axi_resp_t                axil_rresp;

    modport master (
        input  iob_valid, iob_addr, iob_wdata, iob_wstrb,
        output iob_ready, iob_rvalid, iob_rdata,
        output axil_awvalid, axil_awaddr, axil_awprot,
        input  axil_awready,
        output axil_wvalid, axil_wdata, axil_wstrb,
        input  axil_wready,
        input  axil_bvalid, axil_bresp,
        output axil_bready,
        output axil_arvalid, axil_araddr, axil_arprot,
        input  axil_arready,
        input  axil_rvalid, axil_rdata, axil_rresp,
        output axil_rready
    );

    modport slave (
        output iob_valid, iob_addr, iob_wdata, iob_wstrb,
        input  iob_ready, iob_rvalid, iob_rdata,
        input  axil_awvalid, axil_awaddr, axil_awprot,
        output axil_awready,
        input  axil_wvalid, axil_wdata, axil_wstrb,
        output axil_wready,
        output axil_bvalid, axil_bresp,
        input  axil_bready,
        input  axil_arvalid, axil_araddr, axil_arprot,
        output axil_arready,
        output axil_rvalid, axil_rdata, axil_rresp,
        input  axil_rready
    );

endinterface

// File: rtl/iob2axil_bridge.sv
// IOb to AXI-Lite bridge, one outstanding transaction, with response watchdog.
// Latency: request accepted in IDLE; iob_rvalid_o one cycle after the R handshake.
// Backpressure: iob_ready_o low while a transaction is in flight; AXI valids held until ready.
//
// Ports: clk_i, arst_n_i (async active-low); bus_io (master modport: IOb target +
//        AXI-Lite manager); err_clr_i clears the sticky err_o flag (set wins).
module iob2axil_bridge
    import iob2axil_bridge_pkg::*;
#(
    parameter int         AXIL_ADDR_W = 32,
    parameter int         AXIL_DATA_W = 32,
    parameter int         ADDR_W      = AXIL_ADDR_W,
    parameter int         DATA_W      = AXIL_DATA_W,
    parameter logic [2:0] AXIL_PROT   = AXIL_PROT_DEFAULT,
    parameter int         TIMEOUT_W   = 8
) (
    input  logic                clk_i,
    input  logic                arst_n_i,
    iob2axil_bridge_if.master   bus_io,
    input  logic                err_clr_i,
    output logic                err_o
);

    localparam int STRB_W = AXIL_DATA_W / 8;

    // Watchdog gives up on the last count before saturation, so the FSM spends
    // exactly 2^TIMEOUT_W-1 cycles waiting for a response.
    localparam logic [TIMEOUT_W-1:0] WD_MAX  = {TIMEOUT_W{1'b1}};
    localparam logic [TIMEOUT_W-1:0] WD_LAST = WD_MAX - 1'b1;

    state_t                 state_q, state_d;
    logic                   aw_done_q, aw_done_d;
    logic                   w_done_q, w_done_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic [STRB_W-1:0]      wstrb_q, wstrb_d;
    logic [TIMEOUT_W-1:0]   wd_cnt_q, wd_cnt_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic                   rvalid_q, rvalid_d;
    logic                   err_q, err_d;
    logic                   err_set;

    logic                   aw_vld, w_vld, ar_vld;
    logic                   aw_hs, w_hs, ar_hs;
    logic                   aw_fin, w_fin;
    logic                   wd_expire;

    // ------------------------------------------------------------------
    // Channel controls are decoded straight from registered state so that
    // an asynchronous reset drops them at once.
    // ------------------------------------------------------------------
    assign aw_vld = (state_q == WR_ADDR_DATA) && !aw_done_q;
    assign w_vld  = (state_q == WR_ADDR_DATA) && !w_done_q;
    assign ar_vld = (state_q == RD_ADDR);

    assign aw_hs  = aw_vld && bus_io.axil_awready;
    assign w_hs   = w_vld  && bus_io.axil_wready;
    assign ar_hs  = ar_vld && bus_io.axil_arready;

    // A channel counts as finished if it completed earlier or completes now,
    // which lets AW and W finishing in the same cycle move on immediately.
    assign aw_fin = aw_done_q || aw_hs;
    assign w_fin  = w_done_q  || w_hs;

    assign wd_expire = (wd_cnt_q == WD_LAST);

    assign bus_io.iob_ready    = (state_q == IDLE);
    assign bus_io.iob_rvalid   = rvalid_q;
    assign bus_io.iob_rdata    = rdata_q;

    assign bus_io.axil_awvalid = aw_vld;
    assign bus_io.axil_awaddr  = AXIL_ADDR_W'(addr_q);
    assign bus_io.axil_awprot  = AXIL_PROT;

    assign bus_io.axil_wvalid  = w_vld;
    assign bus_io.axil_wdata   = wdata_q;
    assign bus_io.axil_wstrb   = wstrb_q;

    assign bus_io.axil_bready  = (state_q == WR_RESP);

    assign bus_io.axil_arvalid = ar_vld;
    assign bus_io.axil_araddr  = AXIL_ADDR_W'(addr_q);
    assign bus_io.axil_arprot  = AXIL_PROT;

    assign bus_io.axil_rready  = (state_q == RD_RESP);

    assign err_o = err_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        wd_cnt_d  = wd_cnt_q;
        rdata_d   = rdata_q;
        rvalid_d  = 1'b0;
        err_set   = 1'b0;

        unique case (state_q)
            IDLE: begin
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                wd_cnt_d  = '0;
                if (bus_io.iob_valid) begin
                    addr_d  = bus_io.iob_addr;
                    wdata_d = bus_io.iob_wdata;
                    wstrb_d = bus_io.iob_wstrb;
                    state_d = (|bus_io.iob_wstrb) ? WR_ADDR_DATA : RD_ADDR;
                end
            end

            WR_ADDR_DATA: begin
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs)  w_done_d  = 1'b1;
                if (aw_fin && w_fin) state_d = WR_RESP;
            end

            WR_RESP: begin
                if (bus_io.axil_bvalid) begin
                    err_set = resp_is_err(bus_io.axil_bresp);
                    state_d = IDLE;
                end else if (wd_expire) begin
                    err_set  = 1'b1;
                    wd_cnt_d = WD_MAX;
                    state_d  = IDLE;
                end else begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
            end

            RD_ADDR: begin
                if (ar_hs) state_d = RD_RESP;
            end

            RD_RESP: begin
                if (bus_io.axil_rvalid) begin
                    rdata_d  = bus_io.axil_rdata;
                    rvalid_d = 1'b1;
                    err_set  = resp_is_err(bus_io.axil_rresp);
                    state_d  = IDLE;
                end else if (wd_expire) begin
                    // The requester still gets a completion, with zero data,
                    // so it never waits forever on a dead subordinate.
                    rdata_d  = '0;
                    rvalid_d = 1'b1;
                    err_set  = 1'b1;
                    wd_cnt_d = WD_MAX;
                    state_d  = IDLE;
                end else begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Clear first, set last: a same-cycle error keeps the flag raised.
        err_d = err_q;
        if (err_clr_i) err_d = 1'b0;
        if (err_set)   err_d = 1'b1;
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q   <= IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            wd_cnt_q  <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            wd_cnt_q  <= wd_cnt_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: tb/tb_iob2axil_bridge.sv
// Self-checking bench for iob2axil_bridge: random and directed IOb requests,
// a reactive AXI-Lite subordinate with planned delays/responses, and a
// scoreboard monitor that checks every AXI handshake and every IOb read return.
module tb_iob2axil_bridge;
    import iob2axil_bridge_pkg::*;

    logic clk = 1'b0;
    logic arst_n;
    logic err_clr;
    logic err_o;

    always #5 clk = ~clk;

    iob2axil_bridge_if #(.ADDR_W(16), .DATA_W(32), .AXIL_ADDR_W(32), .AXIL_DATA_W(32)) bus ();

    iob2axil_bridge #(
        .AXIL_ADDR_W(32),
        .AXIL_DATA_W(32),
        .ADDR_W     (16),
        .DATA_W     (32),
        .AXIL_PROT  (3'd2),
        .TIMEOUT_W  (4)
    ) dut (
        .clk_i    (clk),
        .arst_n_i (arst_n),
        .bus_io   (bus),
        .err_clr_i(err_clr),
        .err_o    (err_o)
    );

    int total = 0;
    int bad   = 0;

    // Subordinate plan for the transaction in flight (one outstanding).
    int          plan_dly [5];   // 0 AW, 1 W, 2 AR, 3 B, 4 R
    logic [1:0]  plan_resp;
    bit          plan_never;
    logic [31:0] plan_rdata;

    // Scoreboard queues: filled at issue time, drained by the monitor.
    logic [31:0] exp_aw_q[$];
    logic [35:0] exp_w_q[$];
    logic [31:0] exp_ar_q[$];
    logic [31:0] exp_rd_q[$];
    bit          err_model;
    int          exp_wait;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic note_fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s: event not expected or not seen in time", nm);
    endtask

    // ---------------- AXI-Lite subordinate ----------------
    function automatic logic req_of(input int ch);
        case (ch)
            0:       return bus.axil_awvalid;
            1:       return bus.axil_wvalid;
            2:       return bus.axil_arvalid;
            3:       return bus.axil_bready;
            default: return bus.axil_rready;
        endcase
    endfunction

    function automatic logic drv_of(input int ch);
        case (ch)
            0:       return bus.axil_awready;
            1:       return bus.axil_wready;
            2:       return bus.axil_arready;
            3:       return bus.axil_bvalid;
            default: return bus.axil_rvalid;
        endcase
    endfunction

    task automatic set_drv(input int ch, input logic v);
        case (ch)
            0: bus.axil_awready = v;
            1: bus.axil_wready  = v;
            2: bus.axil_arready = v;
            3: begin
                bus.axil_bvalid = v;
                bus.axil_bresp  = v ? plan_resp : 2'b00;
            end
            default: begin
                bus.axil_rvalid = v;
                bus.axil_rdata  = v ? plan_rdata : 32'h0;
                bus.axil_rresp  = v ? plan_resp : 2'b00;
            end
        endcase
    endtask

    // Answers a request plan_dly[ch] cycles after first seeing it, holds until
    // the handshake, then withdraws. Response channels can be told to stay silent.
    task automatic slave(input int ch);
        int n = 0;
        bit armed = 1'b0;
        forever begin
            @(negedge clk);
            if (req_of(ch) && drv_of(ch)) begin
                armed = 1'b0;
                @(posedge clk); #1;
                set_drv(ch, 1'b0);
            end else if (req_of(ch) && !(ch >= 3 && plan_never)) begin
                if (!armed) begin
                    armed = 1'b1;
                    n = plan_dly[ch];
                end
                if (n == 0) begin
                    @(posedge clk); #1;
                    set_drv(ch, 1'b1);
                end else begin
                    n--;
                end
            end
        end
    endtask

    // ---------------- Monitor / scoreboard ----------------
    task automatic monitor();
        int cyc = 0;
        int last_rr = -10;
        bit aw_p = 0, w_p = 0, ar_p = 0;
        bit aw_h = 0, w_h = 0, ar_h = 0, b_h = 0, r_h = 0;
        logic [31:0] aw_a = '0, ar_a = '0;
        logic [35:0] w_v = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!arst_n) begin
                aw_p = 0; w_p = 0; ar_p = 0;
                aw_h = 0; w_h = 0; ar_h = 0; b_h = 0; r_h = 0;
                continue;
            end
            // Pending valids must hold with stable payload.
            if (aw_p) chk("aw_hold", {bus.axil_awvalid, bus.axil_awaddr}, {1'b1, aw_a});
            if (w_p)  chk("w_hold", {bus.axil_wvalid, bus.axil_wstrb, bus.axil_wdata}, {1'b1, w_v});
            if (ar_p) chk("ar_hold", {bus.axil_arvalid, bus.axil_araddr}, {1'b1, ar_a});
            // Each channel carries exactly one beat per transaction.
            if (aw_h) chk("aw_drop", bus.axil_awvalid, 1'b0);
            if (w_h)  chk("w_drop", bus.axil_wvalid, 1'b0);
            if (ar_h) chk("ar_drop", bus.axil_arvalid, 1'b0);
            if (b_h)  chk("bready_drop", bus.axil_bready, 1'b0);
            if (r_h)  chk("rready_drop", bus.axil_rready, 1'b0);

            if (bus.axil_rready) last_rr = cyc;
            if (bus.iob_rvalid) begin
                chk("rvalid_latency", 64'(cyc), 64'(last_rr + 1));
                if (exp_rd_q.size() == 0) note_fail("rvalid_unexpected");
                else chk("iob_rdata", bus.iob_rdata, exp_rd_q.pop_front());
            end

            aw_h = bus.axil_awvalid && bus.axil_awready;
            if (aw_h) begin
                if (exp_aw_q.size() == 0) note_fail("aw_unexpected");
                else chk("awaddr", bus.axil_awaddr, exp_aw_q.pop_front());
                chk("awprot", bus.axil_awprot, 3'd2);
            end
            w_h = bus.axil_wvalid && bus.axil_wready;
            if (w_h) begin
                if (exp_w_q.size() == 0) note_fail("w_unexpected");
                else chk("w_strb_data", {bus.axil_wstrb, bus.axil_wdata}, exp_w_q.pop_front());
            end
            ar_h = bus.axil_arvalid && bus.axil_arready;
            if (ar_h) begin
                if (exp_ar_q.size() == 0) note_fail("ar_unexpected");
                else chk("araddr", bus.axil_araddr, exp_ar_q.pop_front());
                chk("arprot", bus.axil_arprot, 3'd2);
            end
            b_h = bus.axil_bvalid && bus.axil_bready;
            r_h = bus.axil_rvalid && bus.axil_rready;

            aw_p = bus.axil_awvalid && !bus.axil_awready;
            w_p  = bus.axil_wvalid  && !bus.axil_wready;
            ar_p = bus.axil_arvalid && !bus.axil_arready;
            aw_a = bus.axil_awaddr;
            w_v  = {bus.axil_wstrb, bus.axil_wdata};
            ar_a = bus.axil_araddr;
        end
    endtask

    // ---------------- Requester ----------------
    task automatic issue(input bit wr, input logic [15:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input logic [31:0] rdata,
                         input logic [1:0] resp, input bit never,
                         input int d_a, input int d_w, input int d_r, input bit hold_clr);
        bit ok = 1'b0;
        plan_dly[0] = d_a; plan_dly[1] = d_w; plan_dly[2] = d_a;
        plan_dly[3] = d_r; plan_dly[4] = d_r;
        plan_resp = resp; plan_never = never; plan_rdata = rdata;
        if (wr) begin
            exp_aw_q.push_back({16'h0, addr});
            exp_w_q.push_back({wstrb, wdata});
        end else begin
            exp_ar_q.push_back({16'h0, addr});
            exp_rd_q.push_back(never ? 32'h0 : rdata);
        end
        // Response waits d_r+2 cycles with this subordinate; a silent one
        // is abandoned after 2^4-1 cycles.
        exp_wait = never ? 15 : d_r + 2;
        @(posedge clk); #1;
        bus.iob_valid = 1'b1;
        bus.iob_addr  = addr;
        bus.iob_wdata = wdata;
        bus.iob_wstrb = wr ? wstrb : 4'h0;
        if (hold_clr) begin
            err_clr   = 1'b1;
            err_model = 1'b0;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.iob_ready) begin ok = 1'b1; break; end
        end
        if (!ok) note_fail("accept_timeout");
        @(posedge clk); #1;
        // Scramble the request lines: the bridge must have registered them.
        bus.iob_valid = 1'b0;
        bus.iob_addr  = 16'($urandom);
        bus.iob_wdata = $urandom;
        bus.iob_wstrb = 4'($urandom);
    endtask

    task automatic wait_done(input bit err_ev);
        int n = 0;
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.axil_bready || bus.axil_rready) n++;
            if (bus.iob_ready) begin ok = 1'b1; break; end
        end
        err_clr = 1'b0;
        if (!ok) note_fail("done_timeout");
        if (err_ev) err_model = 1'b1;
        chk("resp_wait_cycles", 64'(n), 64'(exp_wait));
        @(negedge clk);
        chk("err_o", err_o, err_model);
        chk("iob_ready_idle", bus.iob_ready, 1'b1);
        chk("sb_drained", 64'(exp_aw_q.size() + exp_w_q.size() + exp_ar_q.size() + exp_rd_q.size()), 64'd0);
    endtask

    task automatic clear_err();
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        err_model = 1'b0;
        @(negedge clk);
        chk("err_cleared", err_o, err_model);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_axi_valids"}, {bus.axil_awvalid, bus.axil_wvalid, bus.axil_arvalid}, 3'b000);
        chk({tag, "_axi_readies"}, {bus.axil_bready, bus.axil_rready}, 2'b00);
        chk({tag, "_iob_rvalid"}, bus.iob_rvalid, 1'b0);
        chk({tag, "_iob_rdata"}, bus.iob_rdata, 32'h0);
        chk({tag, "_err_o"}, err_o, 1'b0);
    endtask

    initial begin
        bit          wr, nv, ok;
        logic [1:0]  rsp;

        arst_n = 1'b0;
        err_clr = 1'b0;
        err_model = 1'b0;
        exp_wait = 0;
        bus.iob_valid = 1'b0; bus.iob_addr = '0; bus.iob_wdata = '0; bus.iob_wstrb = '0;
        bus.axil_awready = 1'b0; bus.axil_wready = 1'b0; bus.axil_arready = 1'b0;
        bus.axil_bvalid = 1'b0; bus.axil_bresp = 2'b00;
        bus.axil_rvalid = 1'b0; bus.axil_rdata = '0; bus.axil_rresp = 2'b00;
        plan_resp = RESP_OKAY; plan_never = 1'b0; plan_rdata = '0;
        for (int i = 0; i < 5; i++) plan_dly[i] = 0;

        fork
            slave(0); slave(1); slave(2); slave(3); slave(4);
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("por");
        @(posedge clk); #3;
        arst_n = 1'b1;
        @(negedge clk);
        chk("por_iob_ready", bus.iob_ready, 1'b1);

        // Read 0x10, arready 2 cycles late, DEADBEEF with OKAY.
        issue(1'b0, 16'h0010, 32'h0, 4'h0, 32'hDEADBEEF, RESP_OKAY, 1'b0, 2, 0, 1, 1'b0);
        wait_done(1'b0);

        // Write A5A5A5A5/F, W accepted well before AW.
        issue(1'b1, 16'h0024, 32'hA5A5A5A5, 4'hF, 32'h0, RESP_OKAY, 1'b0, 3, 0, 0, 1'b0);
        wait_done(1'b0);

        // AW and W accepted in the same cycle.
        issue(1'b1, 16'hFFFC, 32'h0BAD_F00D, 4'h6, 32'h0, RESP_OKAY, 1'b0, 0, 0, 2, 1'b0);
        wait_done(1'b0);

        // SLVERR on B: sticky error, then explicit clear.
        issue(1'b1, 16'h0100, 32'h1111_2222, 4'h1, 32'h0, RESP_SLVERR, 1'b0, 1, 2, 0, 1'b0);
        wait_done(1'b1);
        repeat (3) @(negedge clk);
        chk("err_sticky", err_o, err_model);
        clear_err();

        // Silent read subordinate: watchdog returns zero data and flags error.
        issue(1'b0, 16'h0020, 32'h0, 4'h0, 32'hCAFEF00D, RESP_OKAY, 1'b1, 0, 0, 0, 1'b0);
        wait_done(1'b1);
        clear_err();

        // Silent write subordinate: watchdog aborts with no read return.
        issue(1'b1, 16'h0030, 32'h5555_AAAA, 4'hC, 32'h0, RESP_OKAY, 1'b1, 1, 1, 0, 1'b0);
        wait_done(1'b1);

        // Clear held through a failing read: the error still lands.
        issue(1'b0, 16'h0044, 32'h0, 4'h0, 32'h7777_8888, RESP_SLVERR, 1'b0, 0, 0, 3, 1'b1);
        wait_done(1'b1);
        clear_err();

        // Reset while waiting for B, then a normal read.
        issue(1'b1, 16'h0040, 32'h1234_5678, 4'h3, 32'h0, RESP_OKAY, 1'b1, 0, 0, 0, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.axil_bready) begin ok = 1'b1; break; end
        end
        if (!ok) note_fail("wr_resp_not_reached");
        @(posedge clk); #3;
        arst_n = 1'b0;
        #1;
        chk_reset_vals("mid_rst");
        chk("mid_rst_iob_ready", bus.iob_ready, 1'b1);
        err_model = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        arst_n = 1'b1;
        plan_never = 1'b0;
        issue(1'b0, 16'h0048, 32'h0, 4'h0, 32'h600D_D00D, RESP_OKAY, 1'b0, 1, 0, 2, 1'b0);
        wait_done(1'b0);

        // Random traffic.
        for (int t = 0; t < 40; t++) begin
            wr  = 1'($urandom_range(0, 1));
            rsp = ($urandom_range(0, 7) == 0) ? RESP_SLVERR : RESP_OKAY;
            nv  = ($urandom_range(0, 15) == 0);
            issue(wr, 16'($urandom), $urandom, 4'($urandom_range(1, 15)), $urandom, rsp, nv,
                  int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                  int'($urandom_range(0, 6)), 1'b0);
            wait_done((rsp != RESP_OKAY) || nv);
            if (err_model && $urandom_range(0, 1) == 1) clear_err();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
